// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: FSM encoding, NOP word and default PC width.
package fetch_pkg;

   localparam int unsigned PC_W_DEF  = 9;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched word that IF/ID could not take yet.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            drain_i,
   input  logic            flush_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic [31:0]     data_i,
   output logic            valid_o,
   output logic [PC_W-1:0] pc_o,
   output logic [31:0]     data_o
);

   logic            valid_q;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     data_q;

   // Flush wins over load; load wins over drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         data_q  <= NOP_INSTR;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         data_q  <= data_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to imem (one outstanding), feeds IF/ID.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            pc_sel,
   input  logic [31:0]     br_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            ifid_valid,
   output logic [PC_W-1:0] ifid_pc,
   output logic [31:0]     ifid_instr,
   output logic            fetch_misalign
);

   localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic            drop_q, drop_d;
   logic            req_valid_q, req_valid_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic            misalign_q, misalign_d;

   logic            buf_load, buf_drain, buf_flush, buf_valid;
   logic [PC_W-1:0] buf_pc;
   logic [31:0]     buf_data;
   logic            unused_br_hi;

   assign unused_br_hi = ^br_pc[31:PC_W];

   fetch_buffer #(.PC_W(PC_W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (buf_load),
      .drain_i (buf_drain),
      .flush_i (buf_flush),
      .pc_i    (req_pc_q),
      .data_i  (imem_rsp_data),
      .valid_o (buf_valid),
      .pc_o    (buf_pc),
      .data_o  (buf_data)
   );

   // Next-state: redirect first, then the per-state handshake.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      drop_d       = drop_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      buf_load     = 1'b0;
      buf_drain    = 1'b0;
      buf_flush    = 1'b0;
      misalign_d   = pc_sel && (br_pc[1:0] != 2'b00);

      if (!stall) ifid_valid_d = 1'b0;

      if (pc_sel) begin
         pc_d         = {br_pc[PC_W-1:2], 2'b00};
         ifid_valid_d = 1'b0;
         buf_flush    = 1'b1;
         drop_d       = 1'b0;
         state_d      = S_REQ;
         // The in-flight word must still be swallowed when it shows up.
         if (state_q == S_WAIT && !imem_rsp_valid) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (req_valid_q && imem_req_ready) begin
                  req_pc_d = pc_q;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     pc_d = pc_q + PC_INC;
                     if (!ifid_valid_q || !stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = req_pc_q;
                        ifid_instr_d = imem_rsp_data;
                        state_d      = S_REQ;
                     end else begin
                        buf_load = 1'b1;
                        state_d  = S_FULL;
                     end
                  end
               end
            end
            S_FULL: begin
               if (!stall && buf_valid) begin
                  ifid_valid_d = 1'b1;
                  ifid_pc_d    = buf_pc;
                  ifid_instr_d = buf_data;
                  buf_drain    = 1'b1;
                  state_d      = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end

      req_valid_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         drop_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
         req_valid_q  <= req_valid_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         misalign_q   <= misalign_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign ifid_valid     = ifid_valid_q;
   assign ifid_pc        = ifid_pc_q;
   assign ifid_instr     = ifid_instr_q;
   assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a program-order model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        pc_sel;
   logic [31:0] br_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [8:0]  imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifid_valid;
   logic [8:0]  ifid_pc;
   logic [31:0] ifid_instr;
   logic        fetch_misalign;

   int checks = 0;
   int errors = 0;
   int consumed = 0;

   // Program-order model: next PC the ID stage should receive.
   logic [8:0]  exp_pc;
   logic        exp_mis;
   // Memory model: at most one outstanding request.
   logic        mem_busy;
   logic [8:0]  mem_addr;
   int          mem_cnt;
   int          mem_lat;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .pc_sel         (pc_sel),
      .br_pc          (br_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .fetch_misalign (fetch_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input logic [8:0] a);
      return {20'hABCDE, 3'b000, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: check, drive one cycle of inputs, advance to next falling edge.
   task automatic step(input logic st, input logic ps, input logic [31:0] bp, input logic rdy);
      chk("misalign", 32'(fetch_misalign), 32'(exp_mis));
      if (ifid_valid && !st) begin
         chk("consume_pc", 32'(ifid_pc), 32'(exp_pc));
         chk("consume_instr", ifid_instr, word_of(exp_pc));
         exp_pc = exp_pc + 9'd4;
         consumed++;
      end
      if (ps) exp_pc = {bp[8:2], 2'b00};
      exp_mis = ps && (bp[1:0] != 2'b00);

      imem_rsp_valid = 1'b0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr);
            mem_busy       = 1'b0;
         end
      end
      stall          = st;
      pc_sel         = ps;
      br_pc          = bp;
      imem_req_ready = rdy && !ps;
      if (imem_req_valid && imem_req_ready) begin
         mem_busy = 1'b1;
         mem_addr = imem_req_addr;
         mem_cnt  = mem_lat;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ifid(input string tag);
      for (int n = 0; n < 20 && !ifid_valid; n++) step(1'b0, 1'b0, 32'h0, 1'b1);
      chk({tag, "_timeout"}, 32'(ifid_valid), 32'h1);
   endtask

   task automatic wait_req(input string tag);
      for (int n = 0; n < 20 && !imem_req_valid; n++) step(1'b0, 1'b0, 32'h0, 1'b0);
      chk({tag, "_timeout"}, 32'(imem_req_valid), 32'h1);
   endtask

   initial begin
      logic [8:0]  held_pc;
      logic [31:0] held_instr;
      logic [8:0]  next_pc;

      rst_n = 1'b0;
      stall = 1'b0; pc_sel = 1'b0; br_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      exp_pc = '0; exp_mis = 1'b0;
      mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0; mem_lat = 1;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_ifid_valid", 32'(ifid_valid), 32'h0);
      chk("rst_ifid_pc", 32'(ifid_pc), 32'h0);
      chk("rst_ifid_instr", ifid_instr, 32'h0000_0013);
      chk("rst_misalign", 32'(fetch_misalign), 32'h0);
      rst_n = 1'b1;

      // Free run: IF/ID sees 0,4,8,12 on alternate cycles
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("run_valid", 32'(ifid_valid), 32'h1);
         chk("run_pc", 32'(ifid_pc), 32'(4 * k));
         chk("run_instr", ifid_instr, word_of(9'(4 * k)));
         step(1'b0, 1'b0, 32'h0, 1'b1);
         chk("run_bubble", 32'(ifid_valid), 32'h0);
         step(1'b0, 1'b0, 32'h0, 1'b1);
      end

      // Stall while a response lands in the buffer
      wait_ifid("t2_sync");
      held_pc    = ifid_pc;
      held_instr = ifid_instr;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk("stall_valid", 32'(ifid_valid), 32'h1);
         chk("stall_pc", 32'(ifid_pc), 32'(held_pc));
         chk("stall_instr", ifid_instr, held_instr);
      end
      chk("stall_no_req", 32'(imem_req_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      next_pc = held_pc + 9'd4;
      chk("release_valid", 32'(ifid_valid), 32'h1);
      chk("release_pc", 32'(ifid_pc), 32'(next_pc));
      chk("release_instr", ifid_instr, word_of(next_pc));

      // Redirect while waiting; stale word arrives three cycles later
      wait_req("t3_sync");
      mem_lat = 4;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 32'h40, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("drop_ifid_valid", 32'(ifid_valid), 32'h0);
         chk("drop_no_req", 32'(imem_req_valid), 32'h0);
         step(1'b0, 1'b0, 32'h0, 1'b1);
      end
      chk("drop_req_valid", 32'(imem_req_valid), 32'h1);
      chk("drop_req_addr", 32'(imem_req_addr), 32'h40);
      mem_lat = 1;
      wait_ifid("t3_target");
      chk("drop_target_pc", 32'(ifid_pc), 32'h40);
      chk("drop_target_instr", ifid_instr, word_of(9'h040));

      // Redirect together with stall
      wait_ifid("t4_sync");
      step(1'b1, 1'b1, 32'h80, 1'b1);
      chk("stall_redir_flush", 32'(ifid_valid), 32'h0);
      chk("stall_redir_pc", 32'(imem_req_addr), 32'h80);
      wait_ifid("t4_target");
      chk("stall_redir_target", 32'(ifid_pc), 32'h80);

      // Misaligned target, then wrap at the top of the PC space
      step(1'b0, 1'b1, 32'h106, 1'b1);
      chk("mis_pulse", 32'(fetch_misalign), 32'h1);
      chk("mis_addr", 32'(imem_req_addr), 32'h104);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("mis_one_cycle", 32'(fetch_misalign), 32'h0);
      wait_ifid("t5_mis");
      chk("mis_target_pc", 32'(ifid_pc), 32'h104);
      step(1'b0, 1'b1, 32'h1FC, 1'b1);
      wait_ifid("t5_top");
      chk("wrap_top_pc", 32'(ifid_pc), 32'h1FC);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      wait_ifid("t5_wrap");
      chk("wrap_pc", 32'(ifid_pc), 32'h0);

      // Random traffic against the program-order model
      for (int k = 0; k < 600; k++) begin
         mem_lat = int'($urandom_range(1, 3));
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), $urandom(),
              ($urandom_range(0, 3) != 0));
      end
      mem_lat = 1;
      checks++;
      assert (consumed >= 100) else begin
         errors++;
         $error("FAIL progress: observed %0d consumed expected at least 100", consumed);
      end

      // Asynchronous reset in the middle of a transaction
      wait_req("t6_sync");
      mem_lat = 3;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("arst_req_addr", 32'(imem_req_addr), 32'h0);
      chk("arst_ifid_valid", 32'(ifid_valid), 32'h0);
      chk("arst_ifid_pc", 32'(ifid_pc), 32'h0);
      chk("arst_ifid_instr", ifid_instr, 32'h0000_0013);
      stall = 1'b0; pc_sel = 1'b0; br_pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      mem_busy = 1'b0; exp_pc = '0; exp_mis = 1'b0; mem_lat = 1;
      @(negedge clk);
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("late_rsp_ignored", 32'(ifid_valid), 32'h0);
      wait_ifid("t6_restart");
      chk("restart_pc", 32'(ifid_pc), 32'h0);
      chk("restart_instr", ifid_instr, word_of(9'h000));
      step(1'b0, 1'b0, 32'h0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the branch unit.
- Owns the PC register and consumes pc_sel/br_pc to redirect fetch.
- Issues requests to instruction memory over a valid/ready handshake, buffers the returned word, and drives the IF/ID pipeline register.
- The branch unit reads ifid_pc as its Cur_PC.

Parameters:
- PC_W, 9, PC width in bits (byte address, range 0..2^PC_W-1).
- RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- stall  in  1  ID stage cannot accept a new instruction this cycle.
- pc_sel  in  1  redirect request (taken branch/JAL/JALR).
- br_pc  in  32  redirect target; only [PC_W-1:0] is used.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_W  fetch address.
- imem_rsp_valid  in  1  response word valid. In order, at most one outstanding, arrives 1 or more cycles after acceptance.
- imem_rsp_data  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_pc  out  PC_W  PC of the IF/ID instruction.
- ifid_instr  out  32  IF/ID instruction word.
- fetch_misalign  out  1  one-cycle pulse: the redirect target had br_pc[1:0] != 0.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=S_REQ.
  - Drop flag and buffer valid cleared.
  - ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013 (NOP), imem_req_valid=0, fetch_misalign=0.
  - First request is issued the cycle after rst_n deasserts.
- States:
  - S_REQ:
    - imem_req_valid=1, imem_req_addr=pc.
    - On imem_req_ready: latch req_pc=pc, go S_WAIT.
    - Request stays asserted with a stable address until accepted unless a redirect occurs. On redirect the address changes to the new pc next cycle.
  - S_WAIT:
    - Waits for imem_rsp_valid.
    - If the drop flag is set: discard the word, clear the flag, go S_REQ. pc is not incremented.
    - Else, if IF/ID is free or being consumed this cycle (ifid_valid=0 or stall=0): load IF/ID with {req_pc, data}, set pc=pc+4, go S_REQ.
    - Else: store the word in the 1-entry buffer, set pc=pc+4, go S_FULL.
  - S_FULL:
    - No request issued.
    - When stall=0: buffer moves into IF/ID, buffer cleared, go S_REQ.
- IF/ID update:
  - When stall=0 and no new word is available, ifid_valid becomes 0 (bubble).
  - When stall=1, IF/ID holds all fields unchanged.
- Redirect (pc_sel=1), highest priority, overrides stall:
  - Next cycle: pc={br_pc[PC_W-1:2],2'b00}, ifid_valid=0, buffer cleared.
  - fetch_misalign=1 if br_pc[1:0]!=0.
  - State on redirect:
    - From S_WAIT with no response this cycle: set the drop flag, stay in S_WAIT.
    - From S_WAIT with a response arriving the same cycle: discard it, go S_REQ.
    - From S_REQ or S_FULL: go S_REQ.
- PC arithmetic: pc+4 is modulo 2^PC_W. With PC_W=9, 508 -> 0.
- Latency: with single-cycle memory and no stall, an instruction reaches IF/ID 2 cycles after its request is accepted. Throughput is one instruction per 2 cycles (single outstanding).
- A reset asserted mid-transaction abandons it. Any response arriving after reset is ignored because the state is S_REQ.

Decomposition:
- Shared package: fetch_state_t enum {S_REQ, S_WAIT, S_FULL}, NOP_INSTR=32'h00000013, and the PC_W default constant, shared with the branch unit and datapath.
- One natural sub-module: fetch_buffer, a 1-entry holding register with valid, load, and drain.

Test Plan:
1. Reset then free-run, 1-cycle memory returning addr-tagged words, stall=0 -> ifid_pc sequence 0,4,8,12, each paired with its word; ifid_valid high every other cycle.
2. Hold stall=1 for 5 cycles while a response arrives -> IF/ID unchanged, buffer fills, state S_FULL, no new requests. On stall release, the buffered instruction reaches IF/ID the next cycle with no loss or duplication.
3. Assert pc_sel with br_pc=0x40 while in S_WAIT, with the response arriving 3 cycles later -> stale word dropped, next request addr=0x40, ifid_valid=0 until the 0x40 word arrives.
4. Assert pc_sel=1 together with stall=1 -> redirect taken, IF/ID flushed (ifid_valid=0), pc=target.
5. Redirect with br_pc=0x106 -> fetch_misalign pulses for one cycle, imem_req_addr=0x104. Separately, start at pc=508 -> the next fetch address wraps to 0.
6. Assert rst_n=0 asynchronously mid-S_WAIT, then inject a late rsp_valid -> outputs at reset values immediately, late response ignored, fetch restarts at RESET_PC.
